bcd_mmss_timer: RTL

Parametrised minutes:seconds BCD countdown timer for the microwave controller. It is the successor to the single-minute-digit timer. The operator enters digits serially from the keypad encoder. On each second tick the block counts down, then stops at 00:00 and reports expiry. It adds a configurable minute-digit count, an internal tick prescaler, pause/resume, invalid-digit rejection and a one-cycle expiry pulse for the control FSM.

---
 rtl/timer_pkg.sv | 18 +
 rtl/bcd_digit_dn.sv | 34 +++
 rtl/bcd_mmss_timer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss BCD countdown timer.
// Holds the FSM state enum, BCD limits and a digit validity helper.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX       = 4'd9;
  localparam logic [3:0] SEC_TENS_WRAP = 4'd5;

  function automatic logic bcd_ok(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD down-counting digit with serial shift load and borrow chain.
// Ports: i_shift/i_shift_d load, i_borrow decrement, o_q, o_borrow, o_zero.
module bcd_digit_dn
  import timer_pkg::*;
#(
  parameter logic [3:0] WRAP = BCD_MAX
) (
  input  logic       clock,
  input  logic       clrn,
  input  logic       i_shift,
  input  logic [3:0] i_shift_d,
  input  logic       i_borrow,
  output logic [3:0] o_q,
  output logic       o_borrow,
  output logic       o_zero
);

  logic [3:0] r_q;

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      r_q <= 4'd0;
    end else if (i_shift) begin
      r_q <= i_shift_d;
    end else if (i_borrow) begin
      r_q <= (r_q == 4'd0) ? WRAP : r_q - 4'd1;
    end
  end

  assign o_q      = r_q;
  assign o_zero   = (r_q == 4'd0);
  assign o_borrow = o_zero & i_borrow;

endmodule

// File: rtl/bcd_mmss_timer.sv
// mm:ss BCD countdown timer: serial keypad entry, prescaled tick, pause.
// Ports: clock/clrn, data/loadn/enable in; digits, zero, done, running out.
module bcd_mmss_timer
  import timer_pkg::*;
#(
  parameter int MIN_DIGITS = 1,
  parameter int TICK_DIV   = 1
) (
  input  logic                    clock,
  input  logic                    clrn,
  input  logic [3:0]              data,
  input  logic                    loadn,
  input  logic                    enable,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    zero,
  output logic                    done,
  output logic                    running
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX =
    PW'(TICK_DIV - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_pre;
  logic [PW-1:0]   w_pre_nxt;
  logic            r_done;

  logic            w_valid;
  logic            w_shift;
  logic            w_tick;
  logic            w_expire;
  logic            w_one;

  logic [3:0]      w_so;
  logic [3:0]      w_st;
  logic            w_b_so;
  logic            w_b_st;
  logic            w_z_so;
  logic            w_z_st;

  logic [MIN_DIGITS-1:0][3:0] w_m;
  logic [MIN_DIGITS-1:0][3:0] w_m_in;
  logic [MIN_DIGITS:0]        w_b_m;
  logic [MIN_DIGITS-1:0]      w_z_m;
  logic                       w_unused_borrow;

  assign w_valid = !loadn && bcd_ok(data);

  // Exactly one second left: the next tick expires.
  assign w_one = (w_so == 4'd1) & w_z_st & (&w_z_m);
  assign zero  = w_z_so & w_z_st & (&w_z_m);

  always_comb begin
    w_state_nxt = r_state;
    w_pre_nxt   = r_pre;
    w_shift     = 1'b0;
    w_tick      = 1'b0;
    w_expire    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_shift = w_valid;
        if (enable && !zero) begin
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (!enable) begin
          w_state_nxt = IDLE;
        end else if (r_pre == PRE_MAX) begin
          w_tick    = 1'b1;
          w_pre_nxt = '0;
          if (w_one) begin
            w_expire    = 1'b1;
            w_state_nxt = EXPIRED;
          end
        end else begin
          w_pre_nxt = r_pre + 1'b1;
        end
      end
      EXPIRED: begin
        w_shift = w_valid;
        if (w_valid || !enable) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_shift) begin
      w_pre_nxt = '0;
    end
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      r_state <= IDLE;
      r_pre   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pre   <= w_pre_nxt;
      r_done  <= w_expire;
    end
  end

  bcd_digit_dn #(
    .WRAP (BCD_MAX)
  ) u_sec_ones (
    .clock     (clock),
    .clrn      (clrn),
    .i_shift   (w_shift),
    .i_shift_d (data),
    .i_borrow  (w_tick),
    .o_q       (w_so),
    .o_borrow  (w_b_so),
    .o_zero    (w_z_so)
  );

  bcd_digit_dn #(
    .WRAP (SEC_TENS_WRAP)
  ) u_sec_tens (
    .clock     (clock),
    .clrn      (clrn),
    .i_shift   (w_shift),
    .i_shift_d (w_so),
    .i_borrow  (w_b_so),
    .o_q       (w_st),
    .o_borrow  (w_b_st),
    .o_zero    (w_z_st)
  );

  assign w_b_m[0] = w_b_st;

  // Minute digits form a shift chain above sec_tens.
  for (genvar g = 0; g < MIN_DIGITS; g++) begin : g_min
    if (g == 0) begin : g_lo
      assign w_m_in[g] = w_st;
    end else begin : g_hi
      assign w_m_in[g] = w_m[g-1];
    end

    bcd_digit_dn #(
      .WRAP (BCD_MAX)
    ) u_min (
      .clock     (clock),
      .clrn      (clrn),
      .i_shift   (w_shift),
      .i_shift_d (w_m_in[g]),
      .i_borrow  (w_b_m[g]),
      .o_q       (w_m[g]),
      .o_borrow  (w_b_m[g+1]),
      .o_zero    (w_z_m[g])
    );
  end

  // Expiry stops the count before any borrow can leave the top digit.
  assign w_unused_borrow = w_b_m[MIN_DIGITS];

  assign sec_ones = w_so;
  assign sec_tens = w_st;
  assign mins     = w_m;
  assign done     = r_done;
  assign running  = (r_state == RUN);

endmodule
